// File: rtl/inst_fetch_unit_if.sv
// Fetch-stage bus bundle: I-cache request/response, I-cache flush, decode handoff and control pulses.
// The master modport is the fetch unit's view; slave is the surrounding pipeline and I-cache.
interface inst_fetch_unit_if #(parameter int PC_W = 32);
  logic            ic_req_valid;
  logic            ic_req_ready;
  logic [PC_W-1:0] ic_req_addr;
  logic            ic_resp_valid;
  logic [31:0]     ic_resp_inst;
  logic            ic_flush;
  logic            ic_flush_done;
  logic            id_valid;
  logic [31:0]     id_inst;
  logic [PC_W-1:0] id_pc;
  logic            id_ready;
  logic            redirect_valid;
  logic [PC_W-1:0] redirect_pc;
  logic            flush_icache_req;
  logic            halt_req;
  logic            halted;

  modport master (
    output ic_req_valid, ic_req_addr, ic_flush, id_valid, id_inst, id_pc, halted,
    input  ic_req_ready, ic_resp_valid, ic_resp_inst, ic_flush_done, id_ready,
           redirect_valid, redirect_pc, flush_icache_req, halt_req
  );

  modport slave (
    input  ic_req_valid, ic_req_addr, ic_flush, id_valid, id_inst, id_pc, halted,
    output ic_req_ready, ic_resp_valid, ic_resp_inst, ic_flush_done, id_ready,
           redirect_valid, redirect_pc, flush_icache_req, halt_req
  );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch: PC, single-outstanding I-cache requests, in-order word queue to decode,
// redirect / I-cache flush / halt handling. FETCH_PERF_CNT_EN adds perf_fetched / perf_stall counters.
//
// state          | meaning
// ST_RUN         | normal fetching
// ST_FLUSH_ISSUE | ic_flush pulse driven this cycle
// ST_FLUSH_WAIT  | waiting for ic_flush_done, no requests
// ST_HALTED      | fetch stopped until reset
module inst_fetch_unit #(
  parameter int              PC_W     = 32,
  parameter int              QDEPTH   = 2,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic clk,
  input  logic rst_n,
  inst_fetch_unit_if.master bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);
  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = $clog2(QDEPTH) + 1;
  localparam logic [CNT_W-1:0] QCNT = CNT_W'(QDEPTH);

  localparam logic [1:0] ST_RUN         = 2'd0;
  localparam logic [1:0] ST_FLUSH_ISSUE = 2'd1;
  localparam logic [1:0] ST_FLUSH_WAIT  = 2'd2;
  localparam logic [1:0] ST_HALTED      = 2'd3;

  logic [1:0]       r_state;
  logic [PC_W-1:0]  r_fetch_pc;
  logic [PC_W-1:0]  r_resp_pc;
  logic             r_outstanding;
  logic             r_epoch;
  logic             r_tag;
  logic             r_stale;
  logic [31:0]      r_q_inst [QDEPTH];
  logic [PC_W-1:0]  r_q_pc   [QDEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_run, w_halt, w_redirect, w_flush_go, w_clear;
  logic w_req_valid, w_accept, w_push, w_pop;
  logic w_unused_rpc;

  assign w_run       = (r_state == ST_RUN);
  assign w_halt      = bus.halt_req && (r_state != ST_HALTED);
  assign w_redirect  = bus.redirect_valid && (r_state != ST_HALTED) && !bus.halt_req;
  assign w_flush_go  = w_run && bus.flush_icache_req && !bus.halt_req;
  assign w_clear     = w_halt || w_redirect || w_flush_go;
  // a redirect cycle never issues, so the first request to the new target comes a cycle later
  assign w_req_valid = rst_n && w_run && !r_outstanding && (r_count < QCNT) && !bus.redirect_valid;
  assign w_accept    = w_req_valid && bus.ic_req_ready;
  // r_stale covers the case where two toggles bring the epoch back to the in-flight tag
  assign w_push      = bus.ic_resp_valid && r_outstanding && (r_tag == r_epoch) && !r_stale &&
                       (r_state != ST_HALTED) && !w_clear;
  assign w_pop       = (r_count != '0) && bus.id_ready;
  assign w_unused_rpc = ^bus.redirect_pc[1:0];

  assign bus.ic_req_valid = w_req_valid;
  assign bus.ic_req_addr  = r_fetch_pc;
  assign bus.ic_flush     = (r_state == ST_FLUSH_ISSUE);
  assign bus.id_valid     = (r_count != '0);
  assign bus.id_inst      = r_q_inst[r_rd_ptr];
  assign bus.id_pc        = r_q_pc[r_rd_ptr];
  assign bus.halted       = (r_state == ST_HALTED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_RUN;
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= 1'b0;
      r_epoch       <= 1'b0;
      r_tag         <= 1'b0;
      r_stale       <= 1'b0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        r_q_inst[i] <= '0;
        r_q_pc[i]   <= RESET_PC;
      end
    end else begin
      if (bus.ic_resp_valid) r_outstanding <= 1'b0;
      if (w_accept) begin
        r_outstanding <= 1'b1;
        r_tag         <= r_epoch;
        r_resp_pc     <= r_fetch_pc;
        r_stale       <= w_redirect || w_flush_go;
      end else if (w_redirect || w_flush_go) begin
        r_stale <= 1'b1;
      end

      // a flush holds the PC, so a request accepted in that cycle does not advance it
      if (w_redirect)                    r_fetch_pc <= {bus.redirect_pc[PC_W-1:2], 2'b00};
      else if (w_accept && !w_flush_go)  r_fetch_pc <= r_fetch_pc + PC_W'(4);

      if (w_redirect || w_flush_go) r_epoch <= ~r_epoch;

      if (w_clear) begin
        r_count  <= '0;
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
      end else begin
        if (w_push) begin
          r_q_inst[r_wr_ptr] <= bus.ic_resp_inst;
          r_q_pc[r_wr_ptr]   <= r_resp_pc;
          r_wr_ptr           <= r_wr_ptr + PTR_W'(1);
        end
        if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      end

      if (w_halt) r_state <= ST_HALTED;
      else begin
        case (r_state)
          ST_RUN:         if (bus.flush_icache_req) r_state <= ST_FLUSH_ISSUE;
          ST_FLUSH_ISSUE: r_state <= ST_FLUSH_WAIT;
          ST_FLUSH_WAIT:  if (bus.ic_flush_done) r_state <= ST_RUN;
          default:        r_state <= ST_HALTED;
        endcase
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_fetched <= '0;
      r_perf_stall   <= '0;
    end else begin
      if (w_push && (r_perf_fetched != '1)) r_perf_fetched <= r_perf_fetched + 32'd1;
      if (w_run && (r_count == '0) && (r_perf_stall != '1)) r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_stall   = r_perf_stall;
`endif

  a_resp_has_req: assert property (@(posedge clk) disable iff (!rst_n) bus.ic_resp_valid |-> r_outstanding);

endmodule
